gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a 2-input gate datapath (inputs `a`, `b`, output `y`) in hardware. On `start` it drives the four input vectors in order and holds each for a programmable settle time. It then samples `y` into a 4-bit truth-table register and, optionally, checks the result against an expected table. It sits between a host/BIST controller and any gate instance of the `logic_gates` family, replacing bench-driven stimulus with an on-chip self-test.

---
 rtl/gate_sweep_pkg.sv | 15 +
 rtl/gate_sweep_ctrl_if.sv | 25 ++
 rtl/gate_sweep_settle_cnt.sv | 34 +++
 rtl/gate_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and sizes for the gate sweep sequencer.
// Optional checking is controlled by GATE_SWEEP_CHECK_EN (see gate_sweep_ctrl).
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } gs_state_t;

    localparam int GS_NUM_VEC = 4;
    localparam int GS_IDX_W   = 2;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Host/gate-facing bundle of the sweep sequencer; the slave side is the sequencer.
// start/abort/expected are levels sampled on the rising clock edge; every output is registered.
interface gate_sweep_ctrl_if;
    logic                          start;
    logic                          abort;
    logic [3:0]                    expected;
    logic                          a;
    logic                          b;
    logic                          y;
    logic                          busy;
    logic                          done;
    logic [3:0]                    tt;
    logic                          pass;
    gate_sweep_pkg::gs_state_t     state;

    modport master (
        output start, abort, expected, y,
        input  a, b, busy, done, tt, pass, state
    );

    modport slave (
        input  start, abort, expected, y,
        output a, b, busy, done, tt, pass, state
    );
endinterface

// File: rtl/gate_sweep_settle_cnt.sv
// Settle-time counter: synchronous clear has priority over enable;
// hit flags the last DRIVE cycle of a vector.
module gate_sweep_settle_cnt #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/gate_sweep_ctrl.sv
// On-chip exhaustive sweep of a 2-input gate: drive 00/01/10/11, settle, sample y into tt.
// Define GATE_SWEEP_CHECK_EN to build the expected-table latch and the pass comparator.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    gate_sweep_ctrl_if.slave   bus
);
    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES >= (1 << CNT_W))) begin : g_bad_cfg
        $error("gate_sweep_ctrl: SETTLE_CYCLES must be in 1..2**CNT_W-1");
    end

    gs_state_t           state_q, state_d;
    logic [GS_IDX_W-1:0] idx_q, idx_d;
    logic                a_q, a_d, b_q, b_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [3:0]          tt_q, tt_d;
    logic                pass_q, pass_d;
    logic                cnt_clr, cnt_en, cnt_hit;

`ifdef GATE_SWEEP_CHECK_EN
    logic [3:0]          exp_q, exp_d;
`else
    logic                unused_expected;
    assign unused_expected = ^bus.expected;
`endif

    gate_sweep_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .hit (cnt_hit)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tt_d    = tt_q;
        pass_d  = pass_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef GATE_SWEEP_CHECK_EN
        exp_d   = exp_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d    = DRIVE;
                    idx_d      = '0;
                    {a_d, b_d} = 2'b00;
                    busy_d     = 1'b1;
                    tt_d       = '0;
                    pass_d     = 1'b0;
                    cnt_clr    = 1'b1;
`ifdef GATE_SWEEP_CHECK_EN
                    exp_d      = bus.expected;
`endif
                end
            end
            DRIVE, SAMPLE: begin
                if (bus.abort) begin
                    // Abort discards the partial table so a stale result is never visible.
                    state_d    = IDLE;
                    idx_d      = '0;
                    {a_d, b_d} = 2'b00;
                    busy_d     = 1'b0;
                    tt_d       = '0;
                    pass_d     = 1'b0;
                    cnt_clr    = 1'b1;
                end else if (state_q == DRIVE) begin
                    cnt_en = 1'b1;
                    if (cnt_hit) begin
                        state_d = SAMPLE;
                    end
                end else begin
                    tt_d[idx_q] = bus.y;
                    if (idx_q == GS_IDX_W'(GS_NUM_VEC - 1)) begin
                        state_d    = DONE;
                        {a_d, b_d} = 2'b00;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
`ifdef GATE_SWEEP_CHECK_EN
                        pass_d     = (tt_d == exp_q);
`else
                        pass_d     = 1'b0;
`endif
                    end else begin
                        state_d    = DRIVE;
                        idx_d      = idx_q + GS_IDX_W'(1);
                        {a_d, b_d} = idx_q + GS_IDX_W'(1);
                        cnt_clr    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
        end
    end

`ifdef GATE_SWEEP_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end
`endif

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tt    = tt_q;
    assign bus.pass  = pass_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two lanes (S=2 and S=1), each with a timeline model checked every cycle.
`timescale 1ns/1ps
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    localparam logic [1:0] G_AND  = 2'd0;
    localparam logic [1:0] G_OR   = 2'd1;
    localparam logic [1:0] G_XOR  = 2'd2;
    localparam logic [1:0] G_NAND = 2'd3;

`ifdef GATE_SWEEP_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- lane stimulus / observation ----------------
    logic [1:0]      start_v;
    logic [1:0]      abort_v;
    logic [1:0][3:0] exp_v;
    logic [1:0][1:0] sel_v;
    logic [1:0]      busy_o, done_o, pass_o, a_o, b_o;
    logic [1:0][3:0] tt_o;
    logic [1:0][1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic gate_fn(input logic [1:0] sel, input logic [1:0] v);
        case (sel)
            G_AND:   return v[1] & v[0];
            G_OR:    return v[1] | v[0];
            G_XOR:   return v[1] ^ v[0];
            default: return ~(v[1] & v[0]);
        endcase
    endfunction

    task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", name, lane, $time, act, exp);
        end
    endtask

    for (genvar L = 0; L < 2; L++) begin : g_lane
        localparam int S  = (L == 0) ? 2 : 1;
        localparam int CW = (L == 0) ? 4 : 2;
        localparam int P  = S + 1;

        gate_sweep_ctrl_if sw_if ();
        assign sw_if.start    = start_v[L];
        assign sw_if.abort    = abort_v[L];
        assign sw_if.expected = exp_v[L];
        assign sw_if.y        = gate_fn(sel_v[L], {sw_if.a, sw_if.b});
        assign busy_o[L]  = sw_if.busy;
        assign done_o[L]  = sw_if.done;
        assign pass_o[L]  = sw_if.pass;
        assign a_o[L]     = sw_if.a;
        assign b_o[L]     = sw_if.b;
        assign tt_o[L]    = sw_if.tt;
        assign state_o[L] = sw_if.state;

        gate_sweep_ctrl #(
            .SETTLE_CYCLES (S),
            .CNT_W         (CW)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (sw_if)
        );

        // Timeline model: m_n counts edges since the accepting edge.
        bit         m_act  = 1'b0;
        bit         m_done = 1'b0;
        int         m_n    = 0;
        logic [3:0] m_tt   = '0;
        logic [3:0] m_exp  = '0;
        bit         m_pass = 1'b0;

        always @(posedge clk or posedge rst) begin
            logic [3:0] t;
            int         k;
            if (rst) begin
                m_act <= 1'b0; m_done <= 1'b0; m_n <= 0;
                m_tt <= '0; m_exp <= '0; m_pass <= 1'b0;
            end else begin
                m_done <= 1'b0;
                if (m_act) begin
                    if (abort_v[L]) begin
                        m_act <= 1'b0; m_n <= 0; m_tt <= '0; m_pass <= 1'b0;
                    end else begin
                        k = m_n + 1;
                        t = m_tt;
                        if (k % P == 0) t[k / P - 1] = gate_fn(sel_v[L], 2'(k / P - 1));
                        m_tt <= t;
                        m_n  <= k;
                        if (k == 4 * P) begin
                            m_act  <= 1'b0;
                            m_done <= 1'b1;
                            m_pass <= CHECK && (t == m_exp);
                        end
                    end
                end else if (!m_done && start_v[L] && !abort_v[L]) begin
                    m_act <= 1'b1; m_n <= 0; m_tt <= '0; m_pass <= 1'b0;
                    m_exp <= exp_v[L];
                end
            end
        end

        always @(negedge clk) begin
            logic [1:0] mv;
            mv = m_act ? 2'(m_n / P) : 2'b00;
            check("busy", L, busy_o[L], m_act);
            check("done", L, done_o[L], m_done);
            check("ab",   L, {a_o[L], b_o[L]}, mv);
            check("tt",   L, tt_o[L], m_tt);
            check("pass", L, pass_o[L], m_pass);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        start_v = '0;
        abort_v = '0;
    endtask

    task automatic check_reset_values(input string tag);
        for (int l = 0; l < 2; l++) begin
            check({tag, "_busy"},  l, busy_o[l], 0);
            check({tag, "_done"},  l, done_o[l], 0);
            check({tag, "_ab"},    l, {a_o[l], b_o[l]}, 0);
            check({tag, "_tt"},    l, tt_o[l], 0);
            check({tag, "_pass"},  l, pass_o[l], 0);
            check({tag, "_state"}, l, state_o[l], IDLE);
        end
    endtask

    task automatic run_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (busy_o == 2'b00 && done_o == 2'b00) return;
            @(negedge clk);
        end
        check("idle_timeout", 0, 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dcnt0, dcnt1;
        idle_inputs();
        exp_v = '0;
        sel_v = '0;
        rst = 1'b1;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // AND (lane0, S=2) and NAND (lane1, S=1); re-start pulsed at edge 5 is ignored.
        sel_v[0] = G_AND;  exp_v[0] = 4'b1000;
        sel_v[1] = G_NAND; exp_v[1] = 4'b0111;
        start_v = 2'b11;
        @(negedge clk);
        check("acc_busy", 0, busy_o[0], 1);
        check("acc_busy", 1, busy_o[1], 1);
        for (int e = 1; e <= 13; e++) begin
            start_v = (e == 5) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (e == 3)  check("vec1_ab", 0, {a_o[0], b_o[0]}, 2'b01);
            if (e == 6)  check("vec2_ab", 0, {a_o[0], b_o[0]}, 2'b10);
            if (e == 9)  check("vec3_ab", 0, {a_o[0], b_o[0]}, 2'b11);
            if (e == 11) check("pre_done", 0, done_o[0], 0);
            if (e == 8) begin
                check("s1_done", 1, done_o[1], 1);
                check("s1_tt",   1, tt_o[1], 4'b0111);
                check("s1_pass", 1, pass_o[1], CHECK);
            end
            if (e == 12) begin
                check("and_done", 0, done_o[0], 1);
                check("and_busy", 0, busy_o[0], 0);
                check("and_tt",   0, tt_o[0], 4'b1000);
                check("and_pass", 0, pass_o[0], CHECK);
            end
            if (e == 13) begin
                check("post_done", 0, done_o[0], 0);
                check("hold_tt",   0, tt_o[0], 4'b1000);
            end
        end

        // OR gate against an XOR expectation.
        sel_v = {G_OR, G_OR};
        exp_v = {4'b0110, 4'b0110};
        start_v = 2'b11;
        dcnt0 = 0; dcnt1 = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start_v = 2'b00;
            dcnt0 += int'(done_o[0]);
            dcnt1 += int'(done_o[1]);
        end
        check("or_tt",    0, tt_o[0], 4'b1110);
        check("or_pass",  0, pass_o[0], 0);
        check("or_dones", 0, dcnt0, 1);
        check("or_dones", 1, dcnt1, 1);

        // Abort sampled at edge 7 (vector 2 on lane 0).
        sel_v = {G_AND, G_AND};
        exp_v = {4'b1000, 4'b1000};
        start_v = 2'b11;
        @(negedge clk);
        start_v = 2'b00;
        repeat (6) @(negedge clk);
        abort_v = 2'b11;
        @(negedge clk);
        abort_v = 2'b00;
        check("abort_busy", 0, busy_o[0], 0);
        check("abort_tt",   0, tt_o[0], 0);
        check("abort_pass", 0, pass_o[0], 0);
        dcnt0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dcnt0 += int'(done_o[0]);
        end
        check("abort_nodone", 0, dcnt0, 0);
        start_v = 2'b11;
        @(negedge clk);
        start_v = 2'b00;
        repeat (13) @(negedge clk);
        check("clean_tt",   0, tt_o[0], 4'b1000);
        check("clean_pass", 0, pass_o[0], CHECK);

        // Asynchronous reset while lane 0 is in SAMPLE.
        start_v = 2'b11;
        @(negedge clk);
        start_v = 2'b00;
        repeat (2) @(negedge clk);
        check("pre_rst_state", 0, state_o[0], SAMPLE);
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        start_v = 2'b11;
        @(negedge clk);
        start_v = 2'b00;
        check("rst_restart", 0, busy_o[0], 1);
        run_idle(40);

        // Randomized traffic: random gates, tables, starts and rare aborts.
        for (int i = 0; i < 3000; i++) begin
            for (int l = 0; l < 2; l++) begin
                start_v[l] = ($urandom_range(0, 3) == 0);
                abort_v[l] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 15) == 0) sel_v[l] = 2'($urandom_range(0, 3));
                exp_v[l] = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        idle_inputs();
        run_idle(40);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
